// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between the I-cache and D-cache miss paths.
// The winning request is captured on grant and held on the port until memory answers.
module mem_port_arbiter #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic               i_strobe,
  output logic [31:0]        i_din,
  output logic               i_ready,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic               d_rw,
  input  logic [31:0]        d_dout,
  input  logic               d_strobe,
  output logic [31:0]        d_din,
  output logic               d_ready,
  output logic [A_WIDTH-1:0] m_a,
  output logic               m_rw,
  output logic [31:0]        m_din,
  output logic               m_strobe,
  input  logic [31:0]        m_dout,
  input  logic               m_ready,
  output logic [1:0]         grant,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic [A_WIDTH-1:0] req_a_q, req_a_d;
  logic req_rw_q, req_rw_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic pick_d;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      req_a_q     <= '0;
      req_rw_q    <= 1'b0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      req_a_q     <= req_a_d;
      req_rw_q    <= req_rw_d;
      req_wdata_q <= req_wdata_d;
    end
  end
  // D wins when alone, or on a tie when I was granted last
  always_comb begin
    pick_d      = d_strobe & (~i_strobe | ~last_d_q);
    state_d     = state_q;
    last_d_d    = last_d_q;
    req_a_d     = req_a_q;
    req_rw_d    = req_rw_q;
    req_wdata_d = req_wdata_q;
    if (state_q == IDLE) begin
      if (i_strobe | d_strobe) begin
        state_d     = pick_d ? GNT_D : GNT_I;
        last_d_d    = pick_d;
        req_a_d     = pick_d ? d_a : i_a;
        req_rw_d    = pick_d & d_rw;
        req_wdata_d = pick_d ? d_dout : '0;
      end
    end else if (m_ready) begin
      state_d = IDLE;
    end
  end
  assign m_strobe = state_q != IDLE;
  assign busy     = state_q != IDLE;
  assign grant    = state_q;
  assign m_a      = req_a_q;
  assign m_rw     = req_rw_q;
  assign m_din    = req_wdata_q;
  assign i_din    = m_dout;
  assign d_din    = m_dout;
  // a dropped strobe discards the response while memory still completes
  assign i_ready  = m_ready & i_strobe & (state_q == GNT_I);
  assign d_ready  = m_ready & d_strobe & (state_q == GNT_D);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench; expected transactions are queued in grant order
// and compared on the memory port and the requester response.
module tb_mem_port_arbiter;
  logic clk, clrn;
  logic [31:0] i_a, i_din, d_a, d_dout, d_din, m_a, m_din, m_dout;
  logic i_strobe, i_ready, d_rw, d_strobe, d_ready, m_rw, m_strobe, m_ready, busy;
  logic [1:0] grant;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        side;
    logic [31:0] a;
    logic        rw;
    logic [31:0] wd;
    logic [31:0] rd;
  } txn_t;
  txn_t exp_q[$];

  mem_port_arbiter #(.A_WIDTH(32)) dut (
    .clk(clk), .clrn(clrn),
    .i_a(i_a), .i_strobe(i_strobe), .i_din(i_din), .i_ready(i_ready),
    .d_a(d_a), .d_rw(d_rw), .d_dout(d_dout), .d_strobe(d_strobe), .d_din(d_din), .d_ready(d_ready),
    .m_a(m_a), .m_rw(m_rw), .m_din(m_din), .m_strobe(m_strobe), .m_dout(m_dout), .m_ready(m_ready),
    .grant(grant), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic side, input logic [31:0] a, input logic rw, input logic [31:0] wd,
                      input logic [31:0] rd);
    txn_t t;
    t.side = side; t.a = a; t.rw = rw; t.wd = wd; t.rd = rd;
    exp_q.push_back(t);
  endtask

  always @(negedge clk) if (clrn) chk("ready_excl", {31'b0, i_ready & d_ready}, 32'd0);

  task automatic do_reset();
    step();
    clrn = 0;
    #2;
    chk("rst_m_strobe", m_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_m_a", m_a, 0);
    chk("rst_m_rw", m_rw, 0);
    chk("rst_m_din", m_din, 0);
    chk("rst_ready", {i_ready, d_ready}, 0);
    step();
    step();
    clrn = 1;
    exp_q.delete();
  endtask

  // grant wait, lat grant cycles with m_ready in the last, then one bubble cycle
  task automatic serve(input int lat, input int drop_at, input int exp_wait, input bit rel, input bit raise_other);
    txn_t t;
    int n;
    bit ok;
    n = 0;
    do begin step(); @(negedge clk); n++; end while (m_strobe !== 1'b1 && n < 20);
    chk("grant_wait", n, exp_wait);
    chk("sb_nonempty", {31'b0, exp_q.size() > 0}, 1);
    if (exp_q.size() == 0) return;
    t = exp_q.pop_front();
    ok = (drop_at < 0);
    for (int k = 0; k < lat; k++) begin
      if (k > 0) begin
        step();
        if (k == drop_at) begin if (t.side) d_strobe = 0; else i_strobe = 0; end
        if (raise_other && k == 1) begin if (t.side) i_strobe = 1; else d_strobe = 1; end
        if (t.side) begin d_a = $urandom; d_dout = $urandom; d_rw = ~d_rw; end
        else i_a = $urandom;
        if (k == lat - 1) begin m_ready = 1; m_dout = t.rd; end
        @(negedge clk);
      end
      chk("m_strobe", m_strobe, 1);
      chk("busy", busy, 1);
      chk("grant", grant, t.side ? 2 : 1);
      chk("m_a", m_a, t.a);
      chk("m_rw", m_rw, t.rw);
      chk("m_din", m_din, t.wd);
      if (k == lat - 1) begin
        chk("i_ready", i_ready, !t.side && ok);
        chk("d_ready", d_ready, t.side && ok);
        chk(t.side ? "d_din" : "i_din", t.side ? d_din : i_din, t.rd);
      end else begin
        chk("early_ready", {i_ready, d_ready}, 0);
      end
    end
    step();
    m_ready = 0;
    m_dout = $urandom;
    if (rel) begin if (t.side) d_strobe = 0; else i_strobe = 0; end
    @(negedge clk);
    chk("bubble_grant", grant, 0);
    chk("bubble_busy", busy, 0);
    chk("bubble_m_strobe", m_strobe, 0);
    chk("bubble_ready", {i_ready, d_ready}, 0);
    chk("hold_m_a", m_a, t.a);
    chk("hold_m_din", m_din, t.wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 0; i_a = 0; i_strobe = 0; d_a = 0; d_rw = 0; d_dout = 0; d_strobe = 0;
    m_dout = 0; m_ready = 0;
    do_reset();
    // lone I read
    i_a = 32'h1FC00000; i_strobe = 1;
    push(0, 32'h1FC00000, 0, 0, 32'h24080001);
    serve(3, -1, 1, 1, 0);
    // D write with inputs changing mid-grant
    d_a = 32'h80001000; d_rw = 1; d_dout = 32'hDEADBEEF; d_strobe = 1;
    push(1, 32'h80001000, 1, 32'hDEADBEEF, 32'h13572468);
    serve(4, -1, 1, 1, 0);
    // spurious m_ready while idle
    step();
    m_ready = 1; m_dout = 32'hA5A5A5A5;
    @(negedge clk);
    chk("spur_ready", {i_ready, d_ready}, 0);
    chk("spur_busy", busy, 0);
    step();
    m_ready = 0;
    @(negedge clk);
    chk("spur_busy_next", busy, 0);
    chk("spur_grant", grant, 0);
    // I abort mid-grant, D raised during the grant
    i_a = 32'h00400100; i_strobe = 1;
    d_a = 32'h00800200; d_rw = 0; d_dout = 32'h11111111;
    push(0, 32'h00400100, 0, 0, 32'h99999999);
    push(1, 32'h00800200, 0, 32'h11111111, 32'h77777777);
    serve(4, 1, 1, 1, 1);
    serve(2, -1, 1, 1, 0);
    // continuous contention right after reset: D, I, D, I
    do_reset();
    i_a = 32'h00001000; d_a = 32'h00002000; d_rw = 0; d_dout = 32'h0;
    push(1, 32'h00002000, 0, 0, 32'hD0000001);
    push(0, 32'h00001000, 0, 0, 32'hA0000001);
    i_strobe = 1; d_strobe = 1;
    serve(2, -1, 1, 0, 0);
    d_a = 32'h00002004; d_rw = 1; d_dout = 32'hCAFE0001;
    push(1, 32'h00002004, 1, 32'hCAFE0001, 32'hD0000002);
    serve(3, -1, 1, 0, 0);
    i_a = 32'h00001004;
    push(0, 32'h00001004, 0, 0, 32'hA0000002);
    serve(2, -1, 1, 1, 0);
    serve(2, -1, 1, 1, 0);
    // reset during GNT_D, then tie goes to D
    d_a = 32'h30000000; d_rw = 1; d_dout = 32'h55AA55AA; d_strobe = 1;
    step();
    @(negedge clk);
    chk("pre_rst_grant", grant, 2);
    step();
    clrn = 0;
    #1;
    chk("mid_rst_m_strobe", m_strobe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_m_a", m_a, 0);
    d_strobe = 0;
    step();
    clrn = 1;
    step();
    i_a = 32'h40000000; i_strobe = 1;
    d_a = 32'h50000000; d_rw = 0; d_dout = 32'h0; d_strobe = 1;
    push(1, 32'h50000000, 0, 0, 32'h0BADF00D);
    push(0, 32'h40000000, 0, 0, 32'h600DF00D);
    serve(2, -1, 1, 1, 0);
    serve(3, -1, 1, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
